s2p_deser: RTL and testbench

- Parametrised serial-to-parallel deserialiser for the FFT input datapath.
- Collects LANES consecutive valid samples into one wide word and presents them to the parallel butterfly stage.
- Generates its own lane counter internally; no external counter is needed.
- Tracks frame boundaries, flags the last group of each FFT frame, and detects sync misalignment.

---
 rtl/s2p_pkg.sv | 26 ++
 rtl/s2p_lane_cnt.sv | 52 +++++
 rtl/s2p_deser.sv | 93 +++++++++
 tb/tb_s2p_deser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// Shared constants and helpers for the s2p_deser serial-to-parallel deserialiser.
package s2p_pkg;

   localparam int unsigned S2P_LANES_DEF = 4;
   localparam int unsigned S2P_WL_DEF    = 16;
   localparam int unsigned S2P_FRAME_DEF = 1024;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) width = i + 1;
      end
      return width;
   endfunction

   function automatic int unsigned bitrev(input int unsigned index, input int unsigned width);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < width; i++) begin
         if (index[i]) result = result | (32'd1 << (width - 1 - i));
      end
      return result;
   endfunction

endpackage

// File: rtl/s2p_lane_cnt.sv
// Lane and group counters for s2p_deser, with frame-sync realignment and error pulse.
module s2p_lane_cnt
   import s2p_pkg::*;
#(
   parameter int unsigned LANES     = S2P_LANES_DEF,
   parameter int unsigned FRAME_LEN = S2P_FRAME_DEF,
   localparam int unsigned GROUPS   = FRAME_LEN / LANES,
   localparam int unsigned CNT_W    = clog2(LANES),
   localparam int unsigned GRP_W    = (GROUPS > 1) ? clog2(GROUPS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sync,
   output logic [CNT_W-1:0] lane_cnt,
   output logic [GRP_W-1:0] grp_cnt,
   output logic             grp_done,
   output logic             grp_last,
   output logic             sync_err
);

   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
   localparam logic [GRP_W-1:0] LAST_GRP  = GRP_W'(GROUPS - 1);

   // A sync sample always lands in lane 0, so with LANES >= 2 it never completes a group.
   always_comb begin
      grp_done = in_valid && !in_sync && (lane_cnt == LAST_LANE);
      grp_last = grp_done && (grp_cnt == LAST_GRP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_cnt <= '0;
         grp_cnt  <= '0;
         sync_err <= 1'b0;
      end else begin
         sync_err <= in_valid && in_sync && (lane_cnt != '0);
         if (in_valid) begin
            if (in_sync) begin
               lane_cnt <= CNT_W'(1);
               grp_cnt  <= '0;
            end else begin
               lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
               if (grp_done) begin
                  grp_cnt <= (grp_cnt == LAST_GRP) ? '0 : grp_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/s2p_deser.sv
// Serial-to-parallel deserialiser for the FFT input datapath.
// Define S2P_BITREV_EN to emit each group in bit-reversed lane order.
module s2p_deser
   import s2p_pkg::*;
#(
   parameter int unsigned WORDLENGTH = S2P_WL_DEF,
   parameter int unsigned LANES      = S2P_LANES_DEF,
   parameter int unsigned FRAME_LEN  = S2P_FRAME_DEF,
   localparam int unsigned GROUPS    = FRAME_LEN / LANES,
   localparam int unsigned CNT_W     = clog2(LANES),
   localparam int unsigned GRP_W     = (GROUPS > 1) ? clog2(GROUPS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic                        in_sync,
   input  logic [WORDLENGTH-1:0]       data_in,
   output logic [LANES*WORDLENGTH-1:0] data_out,
   output logic                        out_valid,
   output logic                        out_last,
   output logic                        sync_err
);

   logic [CNT_W-1:0]            lane_cnt;
   logic [GRP_W-1:0]            grp_cnt_unused;
   logic                        grp_done;
   logic                        grp_last;
   logic [CNT_W-1:0]            wr_lane;
   logic [WORDLENGTH-1:0]       stage    [LANES];
   logic [WORDLENGTH-1:0]       grp_lane [LANES];
   logic [LANES*WORDLENGTH-1:0] grp_word;

   s2p_lane_cnt #(
      .LANES     (LANES),
      .FRAME_LEN (FRAME_LEN)
   ) u_lane_cnt (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_sync  (in_sync),
      .lane_cnt (lane_cnt),
      .grp_cnt  (grp_cnt_unused),
      .grp_done (grp_done),
      .grp_last (grp_last),
      .sync_err (sync_err)
   );

   assign wr_lane = in_sync ? '0 : lane_cnt;

   // The final sample bypasses staging so the group is emitted one cycle after it arrives.
   always_comb begin
      for (int unsigned k = 0; k < LANES; k++) begin
         grp_lane[k] = stage[k];
      end
      grp_lane[LANES-1] = data_in;
   end

   always_comb begin
      grp_word = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
`ifdef S2P_BITREV_EN
         grp_word[k*WORDLENGTH +: WORDLENGTH] = grp_lane[CNT_W'(bitrev(k, CNT_W))];
`else
         grp_word[k*WORDLENGTH +: WORDLENGTH] = grp_lane[CNT_W'(k)];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            stage[k] <= '0;
         end
      end else if (in_valid) begin
         stage[wr_lane] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= grp_done;
         out_last  <= grp_last;
         if (grp_done) begin
            data_out <= grp_word;
         end
      end
   end

endmodule

// File: tb/tb_s2p_deser.sv
// Self-checking bench for s2p_deser (WORDLENGTH=16, LANES=4, FRAME_LEN=16) with a scoreboard queue.
module tb_s2p_deser;

   localparam int unsigned WL        = 16;
   localparam int unsigned LANES     = 4;
   localparam int unsigned FRAME_LEN = 16;
   localparam int unsigned GROUPS    = FRAME_LEN / LANES;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_sync;
   logic [WL-1:0]      data_in;
   logic [LANES*WL-1:0] data_out;
   logic               out_valid;
   logic               out_last;
   logic               sync_err;

   int unsigned n_checks;
   int unsigned n_errors;

   // Reference model state
   logic [WL-1:0]       m_buf [LANES];
   int unsigned         m_lane;
   int unsigned         m_grp;
   logic [LANES*WL-1:0] m_dout;
   logic [LANES*WL:0]   exp_q [$];

   s2p_deser #(
      .WORDLENGTH (WL),
      .LANES      (LANES),
      .FRAME_LEN  (FRAME_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sync   (in_sync),
      .data_in   (data_in),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_last  (out_last),
      .sync_err  (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [LANES*WL-1:0] pack_group();
      logic [LANES*WL-1:0] w;
      int unsigned src;
      w = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
`ifdef S2P_BITREV_EN
         src = ((k & 1) << 1) | ((k >> 1) & 1);
`else
         src = k;
`endif
         w[k*WL +: WL] = m_buf[src];
      end
      return w;
   endfunction

   task automatic model_reset();
      m_lane = 0;
      m_grp  = 0;
      m_dout = '0;
      exp_q.delete();
      for (int unsigned k = 0; k < LANES; k++) m_buf[k] = '0;
   endtask

   // Drive one cycle of input, advance the model, then check outputs just after the edge.
   task automatic step(input logic v, input logic s, input logic [WL-1:0] d);
      logic                exp_v;
      logic                exp_err;
      logic [LANES*WL:0]   ent;
      in_valid = v;
      in_sync  = s;
      data_in  = d;
      exp_v   = 1'b0;
      exp_err = 1'b0;
      if (v) begin
         if (s) begin
            exp_err = (m_lane != 0);
            m_lane  = 0;
            m_grp   = 0;
         end
         m_buf[m_lane] = d;
         if (m_lane == LANES - 1) begin
            exp_q.push_back({(m_grp == GROUPS - 1), pack_group()});
            m_grp  = (m_grp == GROUPS - 1) ? 0 : m_grp + 1;
            m_lane = 0;
            exp_v  = 1'b1;
         end else begin
            m_lane++;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", 64'(out_valid), 64'(exp_v));
      check("sync_err", 64'(sync_err), 64'(exp_err));
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 64'(1), 64'(0));
         end else begin
            ent    = exp_q.pop_front();
            m_dout = ent[LANES*WL-1:0];
            check("data_out", data_out, m_dout);
            check("out_last", 64'(out_last), 64'(ent[LANES*WL]));
         end
      end else begin
         check("data_hold", data_out, m_dout);
         check("out_last_idle", 64'(out_last), 64'(0));
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      data_in  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", data_out, 64'h0);
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_last", 64'(out_last), 64'(0));
      check("rst_err", 64'(sync_err), 64'(0));
      rst = 1'b1;

      // Basic group
      step(1'b1, 1'b1, 16'h0001);
      step(1'b1, 1'b0, 16'h0002);
      step(1'b1, 1'b0, 16'h0003);
      step(1'b1, 1'b0, 16'h0004);
`ifdef S2P_BITREV_EN
      check("basic_word", data_out, 64'h0004_0002_0003_0001);
`else
      check("basic_word", data_out, 64'h0004_0003_0002_0001);
`endif
      check("basic_valid", 64'(out_valid), 64'(1));
      step(1'b0, 1'b0, 16'h0000);

      // Full frame
      for (int unsigned i = 0; i < 16; i++) begin
         step(1'b1, (i == 0), WL'(16'h0010 + i));
      end
`ifndef S2P_BITREV_EN
      check("frame_word", data_out, 64'h001F_001E_001D_001C);
`endif
      check("frame_last", 64'(out_last), 64'(1));

      // Gapped input
      for (int unsigned i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, WL'(16'h00A0 + i));
         if (i != 3) step(1'b0, 1'b0, 16'hFFFF);
      end
`ifndef S2P_BITREV_EN
      check("gap_word", data_out, 64'h00A3_00A2_00A1_00A0);
`endif
      step(1'b0, 1'b0, 16'h1234);
      step(1'b0, 1'b1, 16'h5678);

      // Misaligned sync
      step(1'b1, 1'b0, 16'h00B0);
      step(1'b1, 1'b0, 16'h00B1);
      step(1'b1, 1'b1, 16'h00C0);
      check("misalign_err", 64'(sync_err), 64'(1));
      step(1'b1, 1'b0, 16'h00C1);
      step(1'b1, 1'b0, 16'h00C2);
      step(1'b1, 1'b0, 16'h00C3);
`ifndef S2P_BITREV_EN
      check("misalign_word", data_out, 64'h00C3_00C2_00C1_00C0);
`endif

      // Reset mid-group, asserted between clock edges
      step(1'b1, 1'b0, 16'h00E0);
      step(1'b1, 1'b0, 16'h00E1);
      step(1'b1, 1'b0, 16'h00E2);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_data", data_out, 64'h0);
      check("async_rst_valid", 64'(out_valid), 64'(0));
      check("async_rst_last", 64'(out_last), 64'(0));
      check("async_rst_err", 64'(sync_err), 64'(0));
      in_valid = 1'b0;
      in_sync  = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, WL'(16'h00D0 + i));
      end
`ifndef S2P_BITREV_EN
      check("post_rst_word", data_out, 64'h00D3_00D2_00D1_00D0);
`endif

      // Randomised back-to-back traffic with gaps and occasional syncs
      for (int unsigned i = 0; i < 60; i++) begin
         logic v;
         logic s;
         v = ($urandom_range(0, 3) != 0);
         s = ($urandom_range(0, 11) == 0);
         step(v, s, WL'($urandom));
      end
      step(1'b0, 1'b0, 16'h0000);
      check("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
